ram64_fifo_ctrl: RTL

- Synchronous FIFO controller that sits directly upstream of the 64x16 single-port RAM block (RAM64) and uses it as storage.
- Accepts producer writes and consumer reads via valid/ready handshakes.
- Arbitrates the single RAM port and generates the RAM's e/addr/w/r/DIn signals.
- Returns the RAM's DOut to the consumer with a valid flag.

---
 rtl/ram64_fifo_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ram64_fifo_ctrl.sv
// ram64_fifo_ctrl: synchronous FIFO controller that uses the 64x16
// single-port RAM64 block as its storage. Producer writes and consumer
// reads share the one RAM port and are granted one operation per cycle,
// with a priority bit that alternates when both sides request together.
// Read data comes back from the RAM one cycle after the read is accepted.
//
// Optional feature: define FIFO_ERR_EN to add the sticky err_ovf/err_udf
// outputs (write while full / read while empty). Without the macro those
// ports and their logic are absent and illegal requests are just ignored.
module ram64_fifo_ctrl #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_en,
    output logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
`ifdef FIFO_ERR_EN
    output logic          err_ovf,
    output logic          err_udf,
`endif
    output logic          mem_e,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_w,
    output logic          mem_r,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(1 << AW);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          prio;       // 0: writer wins a tie, 1: reader wins a tie
    logic          can_w;
    logic          can_r;
    logic          wr_gnt;
    logic          rd_gnt;
    logic [DW-1:0] rd_data_q;  // last word delivered, held between pulses

    // Flags come straight from the registered count.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign can_w = mem_e && !full;
    assign can_r = mem_e && !empty;

    // Grant at most one RAM operation per cycle; ties resolved by prio.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the if-tree can leave one unassigned and infer a latch.
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (wr_en && rd_en) begin
            if (can_w && can_r) begin
                if (prio) rd_gnt = 1'b1;
                else      wr_gnt = 1'b1;
            end else if (can_w) begin
                wr_gnt = 1'b1;
            end else if (can_r) begin
                rd_gnt = 1'b1;
            end
        end else if (wr_en) begin
            wr_gnt = can_w;
        end else if (rd_en) begin
            rd_gnt = can_r;
        end
    end

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    // Drive the RAM port for the granted operation; idle drives zeros.
    always_comb begin
        mem_w    = 1'b0;
        mem_r    = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (wr_gnt) begin
            mem_w    = 1'b1;
            mem_addr = wr_ptr;
            mem_din  = wr_data;
        end else if (rd_gnt) begin
            mem_r    = 1'b1;
            mem_addr = rd_ptr;
        end
    end

    // RAM enable rises on the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) mem_e <= 1'b0;
        else        mem_e <= 1'b1;
    end

    // Pointers, occupancy and tie-break priority follow the granted op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= 1'b0;
        end else if (wr_gnt) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
            prio   <= 1'b1;
        end else if (rd_gnt) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            count  <= count - CNT_ONE;
            prio   <= 1'b0;
        end
    end

    // Read result tracking: valid pulse one cycle after accept, data held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_valid <= rd_gnt;
            if (rd_valid) rd_data_q <= mem_dout;
        end
    end

    // RAM output passes through while valid, otherwise the last word is held.
    assign rd_data = rd_valid ? mem_dout : rd_data_q;

`ifdef FIFO_ERR_EN
    // Sticky error flags for requests made against a full or empty FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wr_en && full)  err_ovf <= 1'b1;
            if (rd_en && empty) err_udf <= 1'b1;
        end
    end
`endif

endmodule
